gray_fifo_ctrl: RTL and testbench
=================================

// Module: gray_fifo_ctrl
// PURPOSE
//   Pointer/flag controller for a synchronous FIFO whose read and write pointers are kept in Gray code.
//   Sequences an external dual-port RAM: produces write/read addresses, full/empty/count flags and
//   one-cycle error pulses.
//   Gray pointers are exported for later clock-domain-crossing reuse.
//   Binary-to-Gray conversion is done by an instantiated bin2gray sub-module.
// PARAMETERS
//   ADDR_W   4   RAM address width; FIFO depth = 2**ADDR_W (16 entries by default)
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   wr_en        in   1         write request
//   rd_en        in   1         read request
//   wr_addr      out  ADDR_W    RAM write address (low bits of binary write pointer)
//   rd_addr      out  ADDR_W    RAM read address (low bits of binary read pointer)
//   wr_ptr_gray  out  ADDR_W+1  Gray-coded write pointer (registered)
//   rd_ptr_gray  out  ADDR_W+1  Gray-coded read pointer (registered)
//   full         out  1         FIFO holds 2**ADDR_W entries (registered)
//   empty        out  1         FIFO holds 0 entries (registered)
//   count        out  ADDR_W+1  occupancy, 0..2**ADDR_W (registered)
//   overflow     out  1         1-cycle pulse: wr_en while full
//   underflow    out  1         1-cycle pulse: rd_en while empty
// BEHAVIOUR
//   - Reset (rst_n=0, async): all pointers 0, count=0, empty=1, full=0, overflow=underflow=0.
//   - Binary pointers wb, rb are ADDR_W+1 bits wide; the extra MSB is the wrap bit.
//   - Gray conversion: g = b ^ (b >> 1).
//   - Write accept: wa = wr_en & ~full. Read accept: ra = rd_en & ~empty. Both use registered flags.
//   - On each clk edge: wb += wa; rb += ra. Both wrap modulo 2**(ADDR_W+1).
//   - Gray outputs are registered from the next-state binary value, so they are updated in the same
//     edge as wb/rb. Consecutive Gray values differ in exactly one bit, including across wrap.
//   - Addresses are combinational from the current binary pointers:
//     wr_addr = wb[ADDR_W-1:0], rd_addr = rb[ADDR_W-1:0].
//   - RAM write uses wr_addr when wa=1. RAM read data for rd_addr is valid in the cycle ra=1; the RAM is
//     read-first / fall-through, and this controller has no data path.
//   - Flags are computed from the next-state Gray pointers and registered (zero added latency vs pointers):
//       empty_nxt = (wg_nxt == rg_nxt)
//       full_nxt  = (wg_nxt == {~rg_nxt[ADDR_W:ADDR_W-1], rg_nxt[ADDR_W-2:0]})
//       count_nxt = wb_nxt - rb_nxt   (ADDR_W+1-bit modular subtract)
//   - Simultaneous wr_en & rd_en:
//       not full and not empty: both accepted; count and flags unchanged.
//       full: read accepted, write rejected, overflow pulses; next cycle count = depth-1, full=0.
//       empty: write accepted, read rejected, underflow pulses; next cycle count = 1, empty=0.
//   - overflow/underflow are registered: asserted the edge after the offending request, for one cycle per
//     rejected request. A rejected request never moves a pointer.
//   - Reset mid-operation: the FIFO empties immediately. Contents of the external RAM are don't-care.
//   - Invariants: full and empty never both 1. count == 2**ADDR_W iff full. count == 0 iff empty.
// STRUCTURE
//   - Shared package: Gray-code helper constants (GRAY_W = ADDR_W+1) and the FIFO flag struct/typedef
//     {full, empty, overflow, underflow}.
//   - Sub-module bin2gray #(W) instantiated twice (write and read next-state pointers); purely combinational.
//   - Top level: two binary pointer registers, two Gray registers, flag/count registers.
// TESTING
//   1. Reset: assert rst_n=0 mid-stream -> immediately empty=1, full=0, count=0, wr_ptr_gray=rd_ptr_gray=0.
//   2. Fill: 16 single writes from reset -> after the 16th edge full=1, count=16, wr_ptr_gray=5'b11000,
//      wr_addr=0.
//   3. Overflow: wr_en=1 with full=1 -> overflow=1 for one cycle; wr_ptr_gray and count unchanged.
//   4. Full + simultaneous wr/rd: -> rd accepted, wr rejected, overflow=1; next cycle count=15, full=0,
//      rd_ptr_gray=5'b00001.
//   5. Drain/underflow: read until empty=1, then rd_en=1 -> underflow=1 for one cycle; rd_ptr unchanged.
//   6. Wrap: 40 cycles of simultaneous wr/rd at count=3 -> count stays 3; each Gray pointer changes
//      exactly one bit per advance, including the 31->0 wrap (5'b10000->5'b00000).

Source files
------------

// File: rtl/gray_fifo_ctrl_pkg.sv
// Shared types and constants for the Gray-pointer FIFO controller.
package gray_fifo_ctrl_pkg;

  // Default RAM address width; pointers carry one extra wrap bit.
  localparam int ADDR_W_DEF = 4;
  localparam int GRAY_W     = ADDR_W_DEF + 1;

  // Registered status flags, grouped so they share one register.
  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/gray_fifo_ctrl_bin2gray.sv
// Purely combinational binary-to-Gray converter.
module bin2gray #(
  parameter int W = 5
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO with Gray-coded pointers.
// Drives an external dual-port RAM; exports Gray pointers for later CDC reuse.
module gray_fifo_ctrl
  import gray_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wb_q, wb_d, rb_q, rb_d;
  logic [PW-1:0] wg_q, wg_d, rg_q, rg_d;
  logic [PW-1:0] cnt_q, cnt_d;
  fifo_flags_t   flags_q, flags_d;
  logic          wa, ra;

  // Accepts are gated by the registered flags only, so no comb path from flags_d.
  assign wa = wr_en & ~flags_q.full;
  assign ra = rd_en & ~flags_q.empty;

  assign wb_d = wb_q + PW'(wa);
  assign rb_d = rb_q + PW'(ra);

  bin2gray #(.W(PW)) u_wr_b2g (.bin_i(wb_d), .gray_o(wg_d));
  bin2gray #(.W(PW)) u_rd_b2g (.bin_i(rb_d), .gray_o(rg_d));

  // Next flags/count from next-state pointers so they line up with the pointer update.
  always_comb begin
    flags_d           = flags_q;
    flags_d.empty     = (wg_d == rg_d);
    flags_d.full      = (wg_d == {~rg_d[ADDR_W:ADDR_W-1], rg_d[ADDR_W-2:0]});
    flags_d.overflow  = wr_en & flags_q.full;
    flags_d.underflow = rd_en & flags_q.empty;
    cnt_d             = wb_d - rb_d;
  end

  // Pointer, Gray, flag and count registers; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q    <= '0;
      rb_q    <= '0;
      wg_q    <= '0;
      rg_q    <= '0;
      cnt_q   <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wg_q    <= wg_d;
      rg_q    <= rg_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign wr_addr     = wb_q[ADDR_W-1:0];
  assign rd_addr     = rb_q[ADDR_W-1:0];
  assign wr_ptr_gray = wg_q;
  assign rd_ptr_gray = rg_q;
  assign count       = cnt_q;
  assign full        = flags_q.full;
  assign empty       = flags_q.empty;
  assign overflow    = flags_q.overflow;
  assign underflow   = flags_q.underflow;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl: fill, overflow, drain, underflow, wrap, async reset.
module tb_gray_fifo_ctrl;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [PW-1:0] wr_ptr_gray, rd_ptr_gray, count;
  logic          full, empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  gray_fifo_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then settle just past the edge.
  task automatic step(input logic w, input logic r);
    wr_en = w;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] g(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  int mw, mr;
  logic [PW-1:0] pwg, prg;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_wg", wr_ptr_gray, 0);
    chk("rst_rg", rd_ptr_gray, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst_n = 1'b1;
    mw = 0; mr = 0;

    // Fill 16 entries
    for (int i = 1; i <= 16; i++) begin
      chk("fill_waddr", wr_addr, 32'((i - 1) % 16));
      step(1, 0);
      mw++;
      chk("fill_count", count, 32'(i));
      chk("fill_wg", wr_ptr_gray, g(i));
      chk("fill_empty", empty, 0);
      chk("fill_full", full, (i == 16) ? 1 : 0);
    end
    chk("full_wg", wr_ptr_gray, 5'b11000);
    chk("full_waddr", wr_addr, 0);

    // Overflow while full
    step(1, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_wg", wr_ptr_gray, 5'b11000);
    chk("ovf_count", count, 16);
    step(0, 0);
    chk("ovf_clear", overflow, 0);
    chk("ovf_count2", count, 16);

    // Full with simultaneous write/read
    step(1, 1);
    mr++;
    chk("fwr_ovf", overflow, 1);
    chk("fwr_count", count, 15);
    chk("fwr_full", full, 0);
    chk("fwr_rg", rd_ptr_gray, 5'b00001);
    chk("fwr_wg", wr_ptr_gray, 5'b11000);
    step(0, 0);
    chk("fwr_ovf_clr", overflow, 0);

    // Drain
    for (int i = 14; i >= 0; i--) begin
      chk("drn_raddr", rd_addr, 32'(mr % 16));
      step(0, 1);
      mr++;
      chk("drn_count", count, 32'(i));
      chk("drn_rg", rd_ptr_gray, g(mr));
      chk("drn_empty", empty, (i == 0) ? 1 : 0);
      chk("drn_full", full, 0);
    end
    chk("drn_rg_end", rd_ptr_gray, 5'b11000);

    // Underflow while empty
    step(0, 1);
    chk("unf_pulse", underflow, 1);
    chk("unf_rg", rd_ptr_gray, 5'b11000);
    chk("unf_count", count, 0);
    step(0, 0);
    chk("unf_clear", underflow, 0);

    // Empty with simultaneous write/read
    step(1, 1);
    mw++;
    chk("ewr_unf", underflow, 1);
    chk("ewr_count", count, 1);
    chk("ewr_empty", empty, 0);
    chk("ewr_rg", rd_ptr_gray, 5'b11000);
    chk("ewr_wg", wr_ptr_gray, g(17));

    // Two more writes to reach count 3
    step(1, 0); mw++;
    step(1, 0); mw++;
    chk("pre_wrap_count", count, 3);
    chk("pre_wrap_unf", underflow, 0);

    // 40 cycles of simultaneous write/read across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      pwg = wr_ptr_gray;
      prg = rd_ptr_gray;
      step(1, 1);
      mw++; mr++;
      chk("wrap_count", count, 3);
      chk("wrap_wg", wr_ptr_gray, g(mw));
      chk("wrap_rg", rd_ptr_gray, g(mr));
      chk("wrap_wg_1bit", $countones(pwg ^ wr_ptr_gray), 1);
      chk("wrap_rg_1bit", $countones(prg ^ rd_ptr_gray), 1);
      chk("wrap_flags", {full, empty, overflow, underflow}, 0);
      if ((mw % 32) == 0) begin
        chk("wrap_wg_from", pwg, 5'b10000);
        chk("wrap_wg_to", wr_ptr_gray, 5'b00000);
      end
    end
    chk("wrap_waddr", wr_addr, 32'(mw % 16));
    chk("wrap_raddr", rd_addr, 32'(mr % 16));

    // Asynchronous reset mid-stream, checked before the next edge
    wr_en = 1'b1; rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_count", count, 0);
    chk("arst_wg", wr_ptr_gray, 0);
    chk("arst_rg", rd_ptr_gray, 0);
    chk("arst_waddr", wr_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
